// File: rtl/registro_pkg.sv
// rtl/registro_pkg.sv - shared mode encodings and FSM state type for the universal shift register
package registro_pkg;

    typedef enum logic [1:0] {
        MODO_SERIAL = 2'b00,
        MODO_ROTAR  = 2'b01,
        MODO_CARGA  = 2'b10,
        MODO_ARIT   = 2'b11
    } modo_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } estado_t;

    localparam logic DIR_IZQ = 1'b0;
    localparam logic DIR_DER = 1'b1;

endpackage

// File: rtl/paso_desplazamiento.sv
// rtl/paso_desplazamiento.sv - combinational single step (shift, rotate, load, arithmetic shift)
module paso_desplazamiento
    import registro_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       modo,
    input  logic             dir,
    input  logic             s_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    logic fill;

    // fill is the bit that enters at the end opposite to the departing bit
    always_comb begin
        fill = s_in;
        case (modo)
            MODO_SERIAL: fill = s_in;
            MODO_ROTAR:  fill = (dir == DIR_DER) ? q[0] : q[WIDTH-1];
            MODO_ARIT:   fill = (dir == DIR_DER) ? q[WIDTH-1] : 1'b0;
            default:     fill = s_in;
        endcase
    end

    always_comb begin
        q_next  = q;
        bit_out = 1'b0;
        if (modo == MODO_CARGA) begin
            q_next  = d;
            bit_out = 1'b0;
        end else if (dir == DIR_DER) begin
            q_next  = {fill, q[WIDTH-1:1]};
            bit_out = q[0];
        end else begin
            q_next  = {q[WIDTH-2:0], fill};
            bit_out = q[WIDTH-1];
        end
    end

endmodule

// File: rtl/registro_universal_n.sv
// rtl/registro_universal_n.sv - universal N-bit shift register with multi-step burst FSM
module registro_universal_n
    import registro_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic             START,
    input  logic [CNT_W-1:0] CNT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] CNT_CERO = '0;
    localparam logic [CNT_W-1:0] CNT_UNO  = {{(CNT_W-1){1'b0}}, 1'b1};

    estado_t          estado, nxt_estado;
    logic [WIDTH-1:0] q_r, nxt_q;
    logic             s_out_r, nxt_s_out;
    logic             done_r, nxt_done;
    logic [CNT_W-1:0] resto, nxt_resto;
    logic [1:0]       modo_lat, nxt_modo_lat;
    logic             dir_lat, nxt_dir_lat;

    logic [1:0]       sel_modo;
    logic             sel_dir;
    logic [WIDTH-1:0] paso_q;
    logic             paso_bit;

    // One step datapath shared by single steps and bursts; bursts use the latched controls
    assign sel_modo = (estado == RUN) ? modo_lat : MODO;
    assign sel_dir  = (estado == RUN) ? dir_lat  : DIR;

    paso_desplazamiento #(
        .WIDTH (WIDTH)
    ) u_paso (
        .q       (q_r),
        .modo    (sel_modo),
        .dir     (sel_dir),
        .s_in    (S_IN),
        .d       (D),
        .q_next  (paso_q),
        .bit_out (paso_bit)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            estado   <= IDLE;
            q_r      <= '0;
            s_out_r  <= 1'b0;
            done_r   <= 1'b0;
            resto    <= '0;
            modo_lat <= MODO_SERIAL;
            dir_lat  <= DIR_IZQ;
        end else begin
            estado   <= nxt_estado;
            q_r      <= nxt_q;
            s_out_r  <= nxt_s_out;
            done_r   <= nxt_done;
            resto    <= nxt_resto;
            modo_lat <= nxt_modo_lat;
            dir_lat  <= nxt_dir_lat;
        end
    end

    // resto holds the steps still owed after the current edge
    always_comb begin
        nxt_estado   = estado;
        nxt_q        = q_r;
        nxt_s_out    = s_out_r;
        nxt_done     = 1'b0;
        nxt_resto    = resto;
        nxt_modo_lat = modo_lat;
        nxt_dir_lat  = dir_lat;
        case (estado)
            IDLE: begin
                if (ENB) begin
                    if (START) begin
                        if (MODO == MODO_CARGA) begin
                            nxt_q     = paso_q;
                            nxt_s_out = paso_bit;
                            nxt_done  = 1'b1;
                        end else if (CNT == CNT_CERO) begin
                            nxt_done = 1'b1;
                        end else begin
                            nxt_q     = paso_q;
                            nxt_s_out = paso_bit;
                            if (CNT == CNT_UNO) begin
                                nxt_done = 1'b1;
                            end else begin
                                nxt_estado   = RUN;
                                nxt_resto    = CNT - CNT_UNO;
                                nxt_modo_lat = MODO;
                                nxt_dir_lat  = DIR;
                            end
                        end
                    end else begin
                        nxt_q     = paso_q;
                        nxt_s_out = paso_bit;
                    end
                end
            end
            RUN: begin
                if (ENB) begin
                    nxt_q     = paso_q;
                    nxt_s_out = paso_bit;
                    if (resto == CNT_UNO) begin
                        nxt_estado = IDLE;
                        nxt_resto  = CNT_CERO;
                        nxt_done   = 1'b1;
                    end else begin
                        nxt_resto = resto - CNT_UNO;
                    end
                end
            end
            default: begin
                nxt_estado = IDLE;
                nxt_resto  = CNT_CERO;
            end
        endcase
    end

    assign Q     = q_r;
    assign S_OUT = s_out_r;
    assign BUSY  = (estado == RUN);
    assign DONE  = done_r;

endmodule

// File: tb/tb_registro_universal_n.sv
// tb/tb_registro_universal_n.sv - scoreboard bench for registro_universal_n
module tb_registro_universal_n;

    localparam int W = 8;
    localparam int MASK = 255;

    logic       clk = 1'b0;
    logic       RST, ENB, DIR, S_IN, START;
    logic [1:0] MODO;
    logic [3:0] CNT;
    logic [7:0] D;
    logic [7:0] Q;
    logic       S_OUT, BUSY, DONE;

    registro_universal_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .RST   (RST),
        .ENB   (ENB),
        .DIR   (DIR),
        .S_IN  (S_IN),
        .MODO  (MODO),
        .START (START),
        .CNT   (CNT),
        .D     (D),
        .Q     (Q),
        .S_OUT (S_OUT),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       s;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    int m_q = 0, m_sout = 0, m_run = 0, m_done = 0, m_rem = 0, m_mode = 0, m_dir = 0;

    function automatic void model_step(input int modo, input int dir, input int sin);
        int msb = (m_q >> (W - 1)) & 1;
        int lsb = m_q & 1;
        int fill = sin;
        if (modo == 1) fill = dir ? lsb : msb;
        if (modo == 3) fill = dir ? msb : 0;
        if (dir) begin
            m_q = (m_q >> 1) | (fill << (W - 1));
            m_sout = lsb;
        end else begin
            m_q = ((m_q << 1) & MASK) | fill;
            m_sout = msb;
        end
    endfunction

    function automatic void model_next(input int rst, input int enb, input int start,
                                       input int modo, input int dir, input int sin,
                                       input int cnt, input int d);
        if (rst != 0) begin
            m_q = 0; m_sout = 0; m_run = 0; m_done = 0; m_rem = 0;
            return;
        end
        m_done = 0;
        if (enb == 0) return;
        if (m_run != 0) begin
            model_step(m_mode, m_dir, sin);
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_run = 0;
                m_done = 1;
            end
        end else if (modo == 2) begin
            m_q = d; m_sout = 0;
            if (start != 0) m_done = 1;
        end else if (start != 0) begin
            if (cnt == 0) m_done = 1;
            else begin
                model_step(modo, dir, sin);
                if (cnt == 1) m_done = 1;
                else begin
                    m_run = 1; m_rem = cnt - 1; m_mode = modo; m_dir = dir;
                end
            end
        end else begin
            model_step(modo, dir, sin);
        end
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_cycle(input int rst, input int enb, input int start, input int modo,
                               input int dir, input int sin, input int cnt, input int d);
        exp_t e;
        #1;
        RST = rst[0]; ENB = enb[0]; START = start[0]; MODO = modo[1:0];
        DIR = dir[0]; S_IN = sin[0]; CNT = cnt[3:0]; D = d[7:0];
        model_next(rst, enb, start, modo, dir, sin, cnt, d);
        e.q = m_q[7:0]; e.s = m_sout[0]; e.busy = m_run[0]; e.done = m_done[0];
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int v);
        drive_cycle(0, 1, 0, 2, 0, 0, 0, v);
    endtask

    // Monitor: outputs are registered, so each falling edge shows the result of the last rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (Q !== e.q || S_OUT !== e.s || BUSY !== e.busy || DONE !== e.done) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t actual q=%h s=%b busy=%b done=%b required q=%h s=%b busy=%b done=%b",
                             $time, Q, S_OUT, BUSY, DONE, e.q, e.s, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        int busy_cnt, done_cnt;
        RST = 1'b1; ENB = 1'b0; START = 1'b0; MODO = 2'b00; DIR = 1'b0;
        S_IN = 1'b0; CNT = 4'd0; D = 8'h00;
        #3;
        check("reset_q", int'(Q), 0);
        check("reset_busy_done", int'({BUSY, DONE, S_OUT}), 0);
        @(negedge clk);
        idle_cycle();

        load(8'hA5);
        drive_cycle(0, 1, 0, 1, 0, 0, 0, 0);
        check("rot_single_q", int'(Q), 8'h4B);
        check("rot_single_sout", int'(S_OUT), 1);

        load(8'h81);
        busy_cnt = 0; done_cnt = 0;
        drive_cycle(0, 1, 1, 1, 1, 0, 3, 0);
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        drive_cycle(0, 1, 0, 0, 0, 1, 0, 0);
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        drive_cycle(0, 1, 0, 0, 0, 1, 0, 0);
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        check("rot_burst_q", int'(Q), 8'h30);
        check("rot_burst_sout", int'(S_OUT), 0);
        idle_cycle();
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        check("rot_burst_busy_cycles", busy_cnt, 2);
        check("rot_burst_done_cycles", done_cnt, 1);

        load(8'h81);
        busy_cnt = 0; done_cnt = 0;
        drive_cycle(0, 1, 1, 1, 1, 0, 3, 0);
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        drive_cycle(0, 1, 0, 2, 0, 0, 0, 8'hFF);
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        for (int i = 0; i < 2; i++) begin
            idle_cycle();
            busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        end
        drive_cycle(0, 1, 1, 3, 0, 0, 7, 0);
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        check("pause_burst_q", int'(Q), 8'h30);
        idle_cycle();
        busy_cnt += int'(BUSY); done_cnt += int'(DONE);
        check("pause_busy_cycles", busy_cnt, 4);
        check("pause_done_cycles", done_cnt, 1);

        load(8'h90);
        drive_cycle(0, 1, 1, 3, 1, 0, 2, 0);
        drive_cycle(0, 1, 0, 0, 0, 1, 0, 0);
        check("arith_burst_q", int'(Q), 8'hE4);
        check("arith_burst_sout", int'(S_OUT), 0);

        load(8'h3C);
        drive_cycle(0, 1, 1, 0, 0, 1, 0, 0);
        check("zero_cnt_q", int'(Q), 8'h3C);
        check("zero_cnt_busy", int'(BUSY), 0);
        check("zero_cnt_done", int'(DONE), 1);
        idle_cycle();
        check("zero_cnt_done_clear", int'(DONE), 0);

        load(8'h55);
        drive_cycle(0, 1, 1, 0, 0, 1, 6, 0);
        drive_cycle(0, 1, 0, 0, 0, 1, 0, 0);
        check("midburst_busy", int'(BUSY), 1);
        #1 RST = 1'b1;
        #1;
        check("async_reset_q", int'(Q), 0);
        check("async_reset_flags", int'({BUSY, DONE, S_OUT}), 0);
        drive_cycle(1, 1, 0, 0, 0, 1, 0, 0);
        drive_cycle(0, 1, 0, 0, 0, 1, 0, 0);
        check("first_step_after_reset", int'(Q), 8'h01);

        for (int i = 0; i < 600; i++) begin
            drive_cycle(($urandom_range(0, 63) == 0) ? 1 : 0,
                        ($urandom_range(0, 9) < 8) ? 1 : 0,
                        ($urandom_range(0, 5) == 0) ? 1 : 0,
                        $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 15), $urandom_range(0, 255));
        end

        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/registro_universal_n.md
REGISTRO_UNIVERSAL_N -- requirements
Module: registro_universal_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (>=2).
REQ-002 SHALL have parameter CNT_W, default 4, width of the burst step count.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ENB  input  1  enable; 0 freezes all state except reset.
REQ-006 SHALL have port DIR  input  1  0 = toward MSB (left), 1 = toward LSB (right).
REQ-007 SHALL have port S_IN  input  1  serial input bit.
REQ-008 SHALL have port MODO  input  2  00 serial shift, 01 rotate, 10 parallel load, 11 arithmetic shift.
REQ-009 SHALL have port START  input  1  request a multi-step burst.
REQ-010 SHALL have port CNT  input  CNT_W  burst step count.
REQ-011 SHALL have port D  input  WIDTH  parallel load data.
REQ-012 SHALL have port Q  output  WIDTH  register contents.
REQ-013 SHALL have port S_OUT  output  1  bit that left the register on the most recent step.
REQ-014 SHALL have port BUSY  output  1  high while a burst is running.
REQ-015 SHALL have port DONE  output  1  one-cycle pulse on burst completion.

Function
REQ-016 The block SHALL implement an FSM with states IDLE and RUN.
REQ-017 In IDLE with ENB=1 and START=0, the block SHALL perform exactly one step per clock per MODO/DIR.
REQ-018 In serial mode, S_IN SHALL enter at the LSB (left shift) or at the MSB (right shift).
REQ-019 In rotate mode, the bit leaving one end SHALL re-enter at the other end.
REQ-020 In arithmetic mode, a left shift SHALL insert 0 at the LSB and a right shift SHALL replicate the MSB.
REQ-021 On every shift or rotate step, S_OUT SHALL take the departing bit (Q[WIDTH-1] when DIR=0, Q[0] when DIR=1).
REQ-022 A parallel load (MODO=10) SHALL set Q=D and S_OUT=0 in one cycle, ignoring DIR.
REQ-023 In IDLE, START=1 with ENB=1, MODO!=10 and CNT>0 SHALL latch MODO, DIR and CNT, perform the first step on the same edge, and enter RUN when CNT>1.
REQ-024 In RUN, the block SHALL perform one step per ENB=1 cycle using the latched MODO/DIR and the live S_IN, ignoring START, MODO, DIR and CNT.
REQ-025 ENB=0 in RUN SHALL pause the burst (Q, S_OUT and remaining count held) with BUSY staying 1.
REQ-026 BUSY SHALL be 1 exactly in RUN, so a burst of N steps with no pauses shows BUSY=1 for N-1 cycles.
REQ-027 On the edge that performs the final step, the block SHALL return to IDLE and set DONE=1 for exactly the following cycle.
REQ-028 START with CNT=0 SHALL leave Q and S_OUT unchanged, keep BUSY at 0, and pulse DONE the next cycle.
REQ-029 START with MODO=10 SHALL perform a load and pulse DONE the next cycle.
REQ-030 START asserted while DONE=1 SHALL be accepted normally (back-to-back bursts).

Reset
REQ-031 RST=1 SHALL immediately force Q=0, S_OUT=0, BUSY=0, DONE=0, state=IDLE and remaining count=0, regardless of clk, including mid-burst.
REQ-032 The first step after RST deasserts SHALL occur on the first rising edge with ENB=1.

Structure
REQ-033 A shared package registro_pkg SHALL hold the MODO encodings and the FSM state type.
REQ-034 A combinational sub-module paso_desplazamiento (inputs Q, MODO, DIR, S_IN, D; outputs next Q and out bit) SHALL compute a single step and SHALL be reused for both single-step and burst operation.

Verification (WIDTH=8)
REQ-035 The bench SHALL check reset: assert RST mid-burst (BUSY=1) -> Q=00, BUSY=0, DONE=0 before the next edge.
REQ-036 The bench SHALL check load then single rotate: load D=A5, then MODO=01 DIR=0 -> Q=4B, S_OUT=1.
REQ-037 The bench SHALL check a rotate burst: Q=81, START with MODO=01 DIR=1 CNT=3 -> Q=30, S_OUT=0, BUSY high 2 cycles, then DONE pulse 1 cycle.
REQ-038 The bench SHALL check an arithmetic burst: Q=90, MODO=11 DIR=1 CNT=2 -> Q=E4, S_OUT=0.
REQ-039 The bench SHALL check a paused burst: repeat the REQ-037 burst with ENB=0 for 2 cycles mid-burst -> identical final Q, BUSY 2 cycles longer.
REQ-040 The bench SHALL check a zero-count burst: START with CNT=0 and Q=3C -> Q=3C, BUSY never 1, DONE pulse next cycle.
